gray_codec_unit: RTL and testbench

Parametrised, registered successor to the 4-bit switch-driven binary-to-Gray converter. It supports four modes: binary-to-Gray, Gray-to-binary, Gray up-counter and Gray down-counter. Conversion results use a valid handshake and have a fixed 2-cycle latency. The counter advances on a prescaled tick, so its output can drive DE10-Lite LEDs directly.

---
 rtl/gray_codec_unit_if.sv | 23 ++
 rtl/gray_codec_unit.sv | 132 +++++++++++++
 tb/tb_gray_codec_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gray_codec_unit_if.sv
// Request/response bundle for the Gray codec: operand/mode in, result/status out.
interface gray_codec_unit_if #(
    parameter int unsigned WIDTH = 4
);
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             cnt_en;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             wrap;
    logic             busy;

    modport master (
        output mode, in_valid, in_data, cnt_en,
        input  out_valid, out_data, wrap, busy
    );

    modport slave (
        input  mode, in_valid, in_data, cnt_en,
        output out_valid, out_data, wrap, busy
    );
endinterface

// File: rtl/gray_codec_unit.sv
// Registered binary<->Gray converter with a prescaled Gray up/down counter.
// Conversions run through a 2-stage pipeline and always win the output
// register; a counter step that collides with one is held off a cycle.
module gray_codec_unit #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input logic               clk,
    input logic               rst,
    gray_codec_unit_if.slave  bus
);
    localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pipeline, counter and output registers
    logic             s1_v_q,  s1_v_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_dir_q, s1_dir_d;
    logic             s2_v_q,  s2_v_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             pend_q,  pend_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             wrap_q,  wrap_d;
    logic             busy_q,  busy_d;

    logic             is_cnt_c;
    logic             count_up_c;
    logic             load_c;
    logic             step_due_c;
    logic             step_c;
    logic             wrap_c;
    logic [WIDTH-1:0] conv_res_c;

    // Next-state for pipeline, prescaler, counter and output register
    always_comb begin
        s1_v_d      = bus.in_valid & ~bus.mode[1];
        s1_data_d   = bus.in_data;
        s1_dir_d    = bus.mode[0];
        s2_v_d      = s1_v_q;
        busy_d      = s1_v_d | s2_v_d;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        pend_d      = pend_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        wrap_d      = 1'b0;

        is_cnt_c    = bus.mode[1];
        count_up_c  = ~bus.mode[0];
        load_c      = is_cnt_c & bus.in_valid;
        step_due_c  = is_cnt_c & bus.cnt_en & (presc_q == PRESC_MAX);
        step_c      = step_due_c & ~load_c & ~s1_v_q;
        wrap_c      = count_up_c ? (cnt_q == {WIDTH{1'b1}}) : (cnt_q == {WIDTH{1'b0}});
        conv_res_c  = s1_dir_q ? gray2bin(s1_data_q) : bin2gray(s1_data_q);

        // Prescaler and count register; a blocked step keeps the prescaler at its terminal value
        if (!is_cnt_c) begin
            presc_d = '0;
        end else if (load_c) begin
            cnt_d   = bus.in_data;
            presc_d = '0;
        end else if (step_c) begin
            cnt_d   = count_up_c ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            presc_d = '0;
        end else if (bus.cnt_en && !step_due_c) begin
            presc_d = presc_q + PW'(1);
        end

        // Output arbitration: conversion first, then load/step/pending counter display
        if (s1_v_q) begin
            out_valid_d = 1'b1;
            out_data_d  = conv_res_c;
            if (load_c) begin
                pend_d = 1'b1;
            end
        end else if (load_c || step_c || pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = bin2gray(cnt_d);
            wrap_d      = step_c & wrap_c;
            pend_d      = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_data_q   <= '0;
            s1_dir_q    <= 1'b0;
            s2_v_q      <= 1'b0;
            cnt_q       <= '0;
            presc_q     <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_data_q   <= s1_data_d;
            s1_dir_q    <= s1_dir_d;
            s2_v_q      <= s2_v_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_gray_codec_unit.sv
// Directed bench for gray_codec_unit: one DUT with TICK_DIV=1, one with TICK_DIV=3.
module tb_gray_codec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gray_codec_unit_if #(.WIDTH(4)) ifa ();
    gray_codec_unit_if #(.WIDTH(4)) ifb ();

    gray_codec_unit #(.WIDTH(4), .TICK_DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    gray_codec_unit #(.WIDTH(4), .TICK_DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifa.mode = 2'b00; ifa.in_valid = 1'b0; ifa.in_data = 4'b0000; ifa.cnt_en = 1'b0;
        ifb.mode = 2'b00; ifb.in_valid = 1'b0; ifb.in_data = 4'b0000; ifb.cnt_en = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", ifa.out_valid); end
        n_cmp++; if (ifa.out_data !== 4'b0000) begin n_err++; $display("FAIL rst_out_data: got %b want 0000", ifa.out_data); end
        n_cmp++; if (ifa.wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap: got %b want 0", ifa.wrap); end
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
        n_cmp++; if (ifb.out_data !== 4'b0000) begin n_err++; $display("FAIL rst_b_out_data: got %b want 0000", ifb.out_data); end
        rst = 1'b0;
    endtask

    task automatic test_bin2gray;
        logic [3:0] din [2] = '{4'b0101, 4'b1111};
        logic [3:0] dexp [2] = '{4'b0111, 4'b1000};
        for (int k = 0; k < 2; k++) begin
            ifa.mode = 2'b00; ifa.in_valid = 1'b1; ifa.in_data = din[k];
            tick();
            ifa.in_valid = 1'b0;
            n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL b2g_early_valid[%0d]: got %b want 0", k, ifa.out_valid); end
            n_cmp++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL b2g_busy[%0d]: got %b want 1", k, ifa.busy); end
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b1) begin n_err++; $display("FAIL b2g_valid[%0d]: got %b want 1", k, ifa.out_valid); end
            n_cmp++; if (ifa.out_data !== dexp[k]) begin n_err++; $display("FAIL b2g_data[%0d]: got %b want %b", k, ifa.out_data, dexp[k]); end
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL b2g_pulse[%0d]: got %b want 0", k, ifa.out_valid); end
            n_cmp++; if (ifa.out_data !== dexp[k]) begin n_err++; $display("FAIL b2g_hold[%0d]: got %b want %b", k, ifa.out_data, dexp[k]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] din [3] = '{4'b0111, 4'b1000, 4'b0000};
        logic [3:0] dexp [3] = '{4'b0101, 4'b1111, 4'b0000};
        ifa.mode = 2'b01;
        for (int k = 0; k < 5; k++) begin
            ifa.in_valid = (k < 3);
            ifa.in_data  = (k < 3) ? din[k] : 4'b0000;
            tick();
            if (k >= 1) begin
                n_cmp++; if (ifa.out_valid !== 1'b1) begin n_err++; $display("FAIL g2b_valid[%0d]: got %b want 1", k, ifa.out_valid); end
                n_cmp++; if (ifa.out_data !== dexp[k-1]) begin n_err++; $display("FAIL g2b_data[%0d]: got %b want %b", k, ifa.out_data, dexp[k-1]); end
            end else begin
                n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL g2b_lat: got %b want 0", ifa.out_valid); end
            end
            n_cmp++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL g2b_busy[%0d]: got %b want 1", k, ifa.busy); end
            if (k == 3) k = 4;
        end
        ifa.in_valid = 1'b0;
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL g2b_end_valid: got %b want 0", ifa.out_valid); end
        n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL g2b_end_busy: got %b want 0", ifa.busy); end
    endtask

    task automatic test_count_up;
        logic [3:0] seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        apply_reset();
        ifa.mode = 2'b10; ifa.cnt_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== seq[k]) begin
                n_err++; $display("FAIL up_step[%0d]: got v=%b d=%b want v=1 d=%b", k, ifa.out_valid, ifa.out_data, seq[k]);
            end
            n_cmp++; if (ifa.wrap !== (k == 15)) begin
                n_err++; $display("FAIL up_wrap[%0d]: got %b want %b", k, ifa.wrap, (k == 15));
            end
        end
        ifa.cnt_en = 1'b0;
    endtask

    task automatic test_count_down;
        apply_reset();
        ifa.mode = 2'b11; ifa.cnt_en = 1'b1;
        tick();
        n_cmp++; if (ifa.out_data !== 4'b1000 || ifa.wrap !== 1'b1) begin
            n_err++; $display("FAIL dn_first: got d=%b w=%b want d=1000 w=1", ifa.out_data, ifa.wrap);
        end
        tick();
        n_cmp++; if (ifa.out_data !== 4'b1001 || ifa.wrap !== 1'b0 || ifa.out_valid !== 1'b1) begin
            n_err++; $display("FAIL dn_second: got d=%b w=%b v=%b want d=1001 w=0 v=1", ifa.out_data, ifa.wrap, ifa.out_valid);
        end
        ifa.cnt_en = 1'b0;
    endtask

    task automatic test_prescale_load;
        logic en_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        ifb.mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            ifb.cnt_en = en_pat[k];
            tick();
            n_cmp++; if (ifb.out_valid !== (k == 4)) begin
                n_err++; $display("FAIL pre_valid[%0d]: got %b want %b", k, ifb.out_valid, (k == 4));
            end
        end
        n_cmp++; if (ifb.out_data !== 4'b0001) begin n_err++; $display("FAIL pre_data: got %b want 0001", ifb.out_data); end
        ifb.cnt_en = 1'b1;
        tick();
        tick();
        ifb.in_valid = 1'b1; ifb.in_data = 4'b1010;
        tick();
        n_cmp++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== 4'b1111 || ifb.wrap !== 1'b0) begin
            n_err++; $display("FAIL load: got v=%b d=%b w=%b want v=1 d=1111 w=0", ifb.out_valid, ifb.out_data, ifb.wrap);
        end
        ifb.in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (ifb.out_valid !== 1'b0 || ifb.out_data !== 4'b1111) begin
            n_err++; $display("FAIL load_hold: got v=%b d=%b want v=0 d=1111", ifb.out_valid, ifb.out_data);
        end
        tick();
        n_cmp++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== 4'b1110) begin
            n_err++; $display("FAIL load_step: got v=%b d=%b want v=1 d=1110", ifb.out_valid, ifb.out_data);
        end
        ifb.cnt_en = 1'b0; ifb.mode = 2'b00;
    endtask

    task automatic test_mode_switch;
        apply_reset();
        ifa.mode = 2'b00; ifa.in_valid = 1'b1; ifa.in_data = 4'b0101;
        tick();
        ifa.mode = 2'b10; ifa.in_valid = 1'b0; ifa.cnt_en = 1'b1;
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'b0111) begin
            n_err++; $display("FAIL sw_conv: got v=%b d=%b want v=1 d=0111", ifa.out_valid, ifa.out_data);
        end
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'b0001) begin
            n_err++; $display("FAIL sw_deferred: got v=%b d=%b want v=1 d=0001", ifa.out_valid, ifa.out_data);
        end
        tick();
        n_cmp++; if (ifa.out_data !== 4'b0011) begin n_err++; $display("FAIL sw_next: got %b want 0011", ifa.out_data); end
        ifa.cnt_en = 1'b0; ifa.mode = 2'b00;
    endtask

    task automatic test_reset_flush;
        apply_reset();
        ifa.mode = 2'b00; ifa.in_valid = 1'b1; ifa.in_data = 4'b0101;
        tick();
        ifa.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 4'b0000 || ifa.wrap !== 1'b0 || ifa.busy !== 1'b0) begin
            n_err++; $display("FAIL flush_outputs: got v=%b d=%b w=%b b=%b want all 0", ifa.out_valid, ifa.out_data, ifa.wrap, ifa.busy);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid[%0d]: got %b want 0", k, ifa.out_valid); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_bin2gray();
        test_back_to_back();
        test_count_up();
        test_count_down();
        test_prescale_load();
        test_mode_switch();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
